fsb_region_controller: RTL and testbench
========================================

Name: fsb_region_controller

Overview:
Parametrised front-side-bus region controller. It replaces the fixed combinational ROM/RAM/bus-control enable decode with N configurable address windows, per-region wait states, optional slave-driven ready, a bus timeout and a registered read-data return. It sits between epRISC_core and the FSB slaves, and gives the core one ready/error handshake per bus cycle.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
REGIONS, 4, number of address windows
REGION_BASE, {32'h1000_0000, 32'h800, 32'h400, 32'h0}, flat vector of bases; region 0 is in the LSBs
REGION_SIZE, {32'h1000_0000, 32'h10, 32'h400, 32'h400}, flat vector of window sizes; a size of 0 disables the region
REGION_WAIT, {4'd0, 4'd1, 4'd0, 4'd0}, flat vector of 4-bit wait-state counts
REGION_EXTRDY, 4'b1000, per-region flag: completion also requires iSlaveReady
TIMEOUT, 64, maximum ACTIVE cycles before a bus error; must be at least 1
ERROR_DATA, 32'hDEAD_BEEF, read data returned on a bus error

Ports:
iClock  in  1  bus clock
iReset  in  1  synchronous, active-high reset
iRequest  in  1  start of a bus cycle; sampled only in IDLE
iWrite  in  1  1 = write cycle, 0 = read cycle
iAddress  in  ADDR_W  bus address
iSlaveReady  in  REGIONS  per-region ready; used only where REGION_EXTRDY is set
iSlaveData  in  REGIONS*DATA_W  flat vector of per-slave read data
oSelect  out  REGIONS  one-hot registered chip select
oWrite  out  1  latched write strobe qualifier
oAddress  out  ADDR_W  latched address
oReady  out  1  one-cycle pulse: cycle complete
oBusError  out  1  one-cycle pulse, coincident with oReady: decode miss or timeout
oReadData  out  DATA_W  registered read data
oBusy  out  1  high whenever state != IDLE

Behaviour:
- Reset takes effect on the next clock edge and aborts any cycle in flight. Every output clears to 0: state=IDLE, oSelect=0, oReady=0, oBusError=0, oReadData=0, oAddress=0, oWrite=0, and both counters clear.
- Region match rule: base <= addr < base+size. The sum is computed at ADDR_W+1 bits so a window ending at 2^ADDR_W does not wrap.
- If windows overlap, the lowest index wins. Disabled regions never match.
- States: IDLE, ACTIVE, DONE, ERROR.
- IDLE with iRequest=1:
  - Latch oAddress and oWrite.
  - On a match: load waitcnt=REGION_WAIT[i], timeout counter=0, set oSelect[i], go to ACTIVE.
  - On no match: go to ERROR; oSelect stays 0.
- iRequest is ignored in every state other than IDLE.
- ACTIVE:
  - oSelect is held.
  - If waitcnt!=0, decrement waitcnt.
  - Completion condition: waitcnt==0 AND (!EXTRDY[i] OR iSlaveReady[i]). When it holds: go to DONE; on a read, capture oReadData from slice i of iSlaveData; on a write, oReadData holds its value.
  - The timeout counter increments every ACTIVE cycle. If it reaches TIMEOUT-1 without completion, go to ERROR.
  - If completion and timeout fall on the same cycle, completion wins.
- DONE: oReady=1 and oSelect=0 for one cycle, then go to IDLE.
- ERROR: oReady=1, oBusError=1, oSelect=0, oReadData=ERROR_DATA (read and write alike) for one cycle, then go to IDLE.
- Latency, with request sampled at edge 0:
  - oSelect high from cycle 1.
  - oReady at cycle 2+W, where W is the wait count (when ext-ready is not gating).
  - Decode miss: oReady/oBusError at cycle 1.
- Throughput: at most one cycle per 3 clocks. A request held high through DONE is re-accepted in IDLE.
- Counter widths: waitcnt is 4 bits; the timeout counter is $clog2(TIMEOUT+1) bits; neither wraps.

Decomposition:
- Package fsb_pkg:
  - state enum {IDLE, ACTIVE, DONE, ERROR}
  - WAIT_W=4
  - default ERROR_DATA
  - helper function that slices the flat parameter vectors
- Sub-module fsb_region_match: purely combinational address-to-one-hot matcher with the priority rule.
- fsb_region_controller holds the FSM, the counters and the data capture.

Test Plan:
- Read at addr 0x410, iSlaveData[1]=0x1234_5678 -> oSelect=4'b0010 at cycle 1; oReady=1, oBusError=0, oReadData=0x1234_5678 at cycle 2.
- Boundary: addr 0x3FF -> oSelect=4'b0001; addr 0x400 -> 4'b0010; addr 0x80F -> 4'b0100; addr 0x810 -> error at cycle 1.
- Wait states: REGION_WAIT[2]=3, read 0x804 -> oSelect held for cycles 1..4, oReady at cycle 5; write cycle -> oReadData unchanged.
- Unmapped 0x1000 read -> cycle 1 oReady=1, oBusError=1, oReadData=0xDEAD_BEEF, oSelect=0; back to IDLE at cycle 2.
- Region 3 with iSlaveReady[3] held 0, TIMEOUT=64 -> oBusError pulse at cycle 65. Repeat with iSlaveReady[3] rising at cycle 10 -> normal oReady at cycle 11.
- iReset=1 at cycle 2 of a region-2 wait cycle -> cycle 3 all outputs 0, oBusy=0. A new request to 0x410 then completes with standard 2-cycle latency.

Source files
------------

// File: rtl/fsb_pkg.sv
// Shared types and helpers for the front-side-bus region controller.
package fsb_pkg;

  localparam int unsigned WAIT_W             = 4;
  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;

  // Widest flat parameter vector and widest single field fieldOf can handle.
  localparam int unsigned FLAT_MAX  = 1024;
  localparam int unsigned FIELD_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    ERROR
  } fsbState_t;

  // Extract field idx (each width bits, field 0 in the LSBs) from a flat vector.
  function automatic logic [FIELD_MAX-1:0] fieldOf(
    input logic [FLAT_MAX-1:0] flat,
    input int unsigned         idx,
    input int unsigned         width
  );
    logic [FIELD_MAX-1:0] mask;
    mask    = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
    fieldOf = FIELD_MAX'(flat >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/fsb_region_match.sv
// Combinational address decoder: one-hot window hit, lowest index wins.
module fsb_region_match
  import fsb_pkg::*;
#(
  parameter int unsigned               ADDR_W      = 32,
  parameter int unsigned               REGIONS     = 4,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE = {32'h1000_0000, 32'h800, 32'h400, 32'h0},
  parameter logic [REGIONS*ADDR_W-1:0] REGION_SIZE = {32'h1000_0000, 32'h10, 32'h400, 32'h400}
) (
  input  logic [ADDR_W-1:0]  iAddress,
  output logic [REGIONS-1:0] oHit,
  output logic               oAny
);

  logic [ADDR_W:0] winBase;
  logic [ADDR_W:0] winSize;
  logic [ADDR_W:0] addrExt;
  logic            found;

  // Walk windows in index order; the first enabled window containing the address claims it.
  always_comb begin
    oHit    = '0;
    found   = 1'b0;
    winBase = '0;
    winSize = '0;
    addrExt = {1'b0, iAddress};
    for (int unsigned i = 0; i < REGIONS; i++) begin
      winBase = {1'b0, ADDR_W'(fieldOf(FLAT_MAX'(REGION_BASE), i, ADDR_W))};
      winSize = {1'b0, ADDR_W'(fieldOf(FLAT_MAX'(REGION_SIZE), i, ADDR_W))};
      // End is formed one bit wider so a window reaching the top of the map does not wrap.
      if (!found && (winSize != '0) && (addrExt >= winBase) && (addrExt < winBase + winSize)) begin
        oHit[i] = 1'b1;
        found   = 1'b1;
      end
    end
    oAny = found;
  end

endmodule

// File: rtl/fsb_region_controller.sv
// FSB region controller: decode, wait states, ext-ready, timeout and read-data return.
module fsb_region_controller
  import fsb_pkg::*;
#(
  parameter int unsigned               ADDR_W        = 32,
  parameter int unsigned               DATA_W        = 32,
  parameter int unsigned               REGIONS       = 4,
  parameter logic [REGIONS*ADDR_W-1:0] REGION_BASE   = {32'h1000_0000, 32'h800, 32'h400, 32'h0},
  parameter logic [REGIONS*ADDR_W-1:0] REGION_SIZE   = {32'h1000_0000, 32'h10, 32'h400, 32'h400},
  parameter logic [REGIONS*WAIT_W-1:0] REGION_WAIT   = {4'd0, 4'd1, 4'd0, 4'd0},
  parameter logic [REGIONS-1:0]        REGION_EXTRDY = 4'b1000,
  parameter int unsigned               TIMEOUT       = 64,
  parameter logic [DATA_W-1:0]         ERROR_DATA    = DEFAULT_ERROR_DATA
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iRequest,
  input  logic                      iWrite,
  input  logic [ADDR_W-1:0]         iAddress,
  input  logic [REGIONS-1:0]        iSlaveReady,
  input  logic [REGIONS*DATA_W-1:0] iSlaveData,
  output logic [REGIONS-1:0]        oSelect,
  output logic                      oWrite,
  output logic [ADDR_W-1:0]         oAddress,
  output logic                      oReady,
  output logic                      oBusError,
  output logic [DATA_W-1:0]         oReadData,
  output logic                      oBusy
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  fsbState_t           state, stateNext;
  logic [WAIT_W-1:0]   waitCnt, waitNext;
  logic [TO_W-1:0]     toCnt, toNext;
  logic [REGIONS-1:0]  selNext;
  logic [ADDR_W-1:0]   addrNext;
  logic                writeNext;
  logic [DATA_W-1:0]   rdataNext;

  logic [REGIONS-1:0]  hitSel;
  logic                hitAny;
  logic [WAIT_W-1:0]   hitWait;
  logic                slaveOk;
  logic [DATA_W-1:0]   selData;

  fsb_region_match #(
    .ADDR_W      (ADDR_W),
    .REGIONS     (REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) uMatch (
    .iAddress (iAddress),
    .oHit     (hitSel),
    .oAny     (hitAny)
  );

  // Wait-state count of the window being decoded this cycle.
  always_comb begin
    hitWait = '0;
    for (int unsigned i = 0; i < REGIONS; i++) begin
      if (hitSel[i]) hitWait = hitWait | WAIT_W'(fieldOf(FLAT_MAX'(REGION_WAIT), i, WAIT_W));
    end
  end

  // Ready and read data of the currently selected slave, muxed by the one-hot select.
  always_comb begin
    slaveOk = 1'b0;
    selData = '0;
    for (int unsigned i = 0; i < REGIONS; i++) begin
      if (oSelect[i]) begin
        slaveOk = slaveOk | !REGION_EXTRDY[i] | iSlaveReady[i];
        selData = selData | iSlaveData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, counter and datapath decisions.
  always_comb begin
    stateNext = state;
    waitNext  = waitCnt;
    toNext    = toCnt;
    selNext   = oSelect;
    addrNext  = oAddress;
    writeNext = oWrite;
    rdataNext = oReadData;
    unique case (state)
      IDLE: begin
        if (iRequest) begin
          addrNext  = iAddress;
          writeNext = iWrite;
          if (hitAny) begin
            stateNext = ACTIVE;
            selNext   = hitSel;
            waitNext  = hitWait;
            toNext    = '0;
          end else begin
            stateNext = ERROR;
            selNext   = '0;
            rdataNext = ERROR_DATA;
          end
        end
      end
      ACTIVE: begin
        if (waitCnt != '0) waitNext = waitCnt - WAIT_W'(1);
        if (toCnt != TO_LAST) toNext = toCnt + TO_W'(1);
        // Completion is tested first so it wins over a coincident timeout.
        if ((waitCnt == '0) && slaveOk) begin
          stateNext = DONE;
          selNext   = '0;
          if (!oWrite) rdataNext = selData;
        end else if (toCnt == TO_LAST) begin
          stateNext = ERROR;
          selNext   = '0;
          rdataNext = ERROR_DATA;
        end
      end
      DONE, ERROR: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        selNext   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any cycle in flight.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      toCnt     <= '0;
      oSelect   <= '0;
      oAddress  <= '0;
      oWrite    <= 1'b0;
      oReadData <= '0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitNext;
      toCnt     <= toNext;
      oSelect   <= selNext;
      oAddress  <= addrNext;
      oWrite    <= writeNext;
      oReadData <= rdataNext;
    end
  end

  // Handshake strobes decoded straight from the state register.
  always_comb begin
    oReady    = (state == DONE) || (state == ERROR);
    oBusError = (state == ERROR);
    oBusy     = (state != IDLE);
  end

endmodule

// File: tb/tb_fsb_region_controller.sv
// Directed, table-driven bench for fsb_region_controller (region 2 given 3 wait states).
module tb_fsb_region_controller;

  logic         iClock = 1'b0;
  logic         iReset;
  logic         iRequest;
  logic         iWrite;
  logic [31:0]  iAddress;
  logic [3:0]   iSlaveReady;
  logic [127:0] iSlaveData;
  logic [3:0]   oSelect;
  logic         oWrite;
  logic [31:0]  oAddress;
  logic         oReady;
  logic         oBusError;
  logic [31:0]  oReadData;
  logic         oBusy;

  int applied     = 0;
  int miscompares = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] seed;
    logic [3:0]  sel;
    int          lat;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [13];

  always #5 iClock = ~iClock;

  fsb_region_controller #(
    .REGION_WAIT ({4'd0, 4'd3, 4'd0, 4'd0}),
    .TIMEOUT     (64)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iRequest    (iRequest),
    .iWrite      (iWrite),
    .iAddress    (iAddress),
    .iSlaveReady (iSlaveReady),
    .iSlaveData  (iSlaveData),
    .oSelect     (oSelect),
    .oWrite      (oWrite),
    .oAddress    (oAddress),
    .oReady      (oReady),
    .oBusError   (oBusError),
    .oReadData   (oReadData),
    .oBusy       (oBusy)
  );

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave i returns seed + i.
  task automatic setData(input logic [31:0] seed);
    for (int i = 0; i < 4; i++) iSlaveData[i*32 +: 32] = seed + 32'(i);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " sel"},   64'(oSelect),   64'h0);
    check({tag, " rdy"},   64'(oReady),    64'h0);
    check({tag, " err"},   64'(oBusError), 64'h0);
    check({tag, " rdata"}, 64'(oReadData), 64'h0);
    check({tag, " addr"},  64'(oAddress),  64'h0);
    check({tag, " wr"},    64'(oWrite),    64'h0);
    check({tag, " busy"},  64'(oBusy),     64'h0);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    iWrite   = v.wr;
    iAddress = v.addr;
    setData(v.seed);
    iRequest = 1'b1;
    tick();
    iRequest = 1'b0;
    iAddress = 32'h0;
    iWrite   = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) tick();
      if (c < v.lat) begin
        check($sformatf("%s c%0d sel", tag, c),  64'(oSelect), 64'(v.sel));
        check($sformatf("%s c%0d rdy", tag, c),  64'(oReady),  64'h0);
        check($sformatf("%s c%0d busy", tag, c), 64'(oBusy),   64'h1);
      end else begin
        check($sformatf("%s rdy", tag),   64'(oReady),    64'h1);
        check($sformatf("%s err", tag),   64'(oBusError), 64'(v.err));
        check($sformatf("%s sel0", tag),  64'(oSelect),   64'h0);
        check($sformatf("%s rdata", tag), 64'(oReadData), 64'(v.data));
        check($sformatf("%s addr", tag),  64'(oAddress),  64'(v.addr));
        check($sformatf("%s wr", tag),    64'(oWrite),    64'(v.wr));
      end
    end
    tick();
    check($sformatf("%s idle rdy", tag),  64'(oReady), 64'h0);
    check($sformatf("%s idle busy", tag), 64'(oBusy),  64'h0);
  endtask

  // Region 3 read with ext-ready held low; readyCycle>0 raises ready during that cycle.
  task automatic runExtReady(input int readyCycle, input logic [31:0] expData, input string tag);
    int last;
    last        = (readyCycle > 0) ? readyCycle + 1 : 65;
    iSlaveReady = 4'b0000;
    iWrite      = 1'b0;
    iAddress    = 32'h1000_0040;
    setData(32'h0000_8000);
    iRequest    = 1'b1;
    tick();
    iRequest = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) tick();
      if (c < last) begin
        check($sformatf("%s c%0d rdy", tag, c), 64'(oReady),  64'h0);
        check($sformatf("%s c%0d sel", tag, c), 64'(oSelect), 64'h8);
      end else begin
        check($sformatf("%s rdy", tag),   64'(oReady),    64'h1);
        check($sformatf("%s err", tag),   64'(oBusError), 64'((readyCycle > 0) ? 1'b0 : 1'b1));
        check($sformatf("%s rdata", tag), 64'(oReadData), 64'(expData));
      end
      if (c == readyCycle) iSlaveReady = 4'b1000;
    end
    tick();
    check($sformatf("%s idle", tag), 64'(oBusy), 64'h0);
    iSlaveReady = 4'b1000;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0410, 32'h1234_5677, 4'b0010, 2, 1'b0, 32'h1234_5678};
    vecs[1]  = '{1'b0, 32'h0000_03FF, 32'h0000_1000, 4'b0001, 2, 1'b0, 32'h0000_1000};
    vecs[2]  = '{1'b0, 32'h0000_0400, 32'h0000_2000, 4'b0010, 2, 1'b0, 32'h0000_2001};
    vecs[3]  = '{1'b0, 32'h0000_080F, 32'h0000_3000, 4'b0100, 5, 1'b0, 32'h0000_3002};
    vecs[4]  = '{1'b0, 32'h0000_0810, 32'h0000_3100, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0000_3200, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h1000_0000, 32'h0000_4000, 4'b1000, 2, 1'b0, 32'h0000_4003};
    vecs[7]  = '{1'b1, 32'h0000_0804, 32'h0000_5000, 4'b0100, 5, 1'b0, 32'h0000_4003};
    vecs[8]  = '{1'b0, 32'h1FFF_FFFF, 32'h0000_6000, 4'b1000, 2, 1'b0, 32'h0000_6003};
    vecs[9]  = '{1'b0, 32'h2000_0000, 32'h0000_6100, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_6200, 4'b0001, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 32'hFFFF_FFF0, 32'h0000_6300, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 32'h0000_07FF, 32'h0000_7000, 4'b0010, 2, 1'b0, 32'h0000_7001};

    iReset      = 1'b1;
    iRequest    = 1'b0;
    iWrite      = 1'b0;
    iAddress    = 32'h0;
    iSlaveReady = 4'b1000;
    iSlaveData  = '0;
    tick();
    tick();
    checkAllZero("reset");
    iReset = 1'b0;
    tick();

    for (int n = 0; n < 13; n++) runVec(vecs[n], $sformatf("v%0d", n));

    // Ext-ready never arrives: timeout error at cycle 65.
    runExtReady(0, 32'hDEAD_BEEF, "tmo");
    // Ext-ready rises in cycle 10: normal completion at cycle 11.
    runExtReady(10, 32'h0000_8003, "xrdy");

    // Request held high through DONE is re-accepted once back in IDLE.
    iWrite   = 1'b0;
    iAddress = 32'h0000_0410;
    setData(32'h0000_9000);
    iRequest = 1'b1;
    tick();
    check("hold c1 sel", 64'(oSelect), 64'h2);
    tick();
    check("hold c2 rdy", 64'(oReady), 64'h1);
    check("hold c2 data", 64'(oReadData), 64'h0000_9001);
    tick();
    check("hold c3 busy", 64'(oBusy), 64'h0);
    tick();
    check("hold c4 sel", 64'(oSelect), 64'h2);
    iRequest = 1'b0;
    tick();
    check("hold c5 rdy", 64'(oReady), 64'h1);
    tick();
    check("hold c6 busy", 64'(oBusy), 64'h0);

    // Reset during a region-2 wait cycle aborts it.
    iAddress = 32'h0000_0804;
    iRequest = 1'b1;
    tick();
    iRequest = 1'b0;
    check("rst c1 sel", 64'(oSelect), 64'h4);
    tick();
    check("rst c2 sel", 64'(oSelect), 64'h4);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    checkAllZero("rst c3");
    runVec(vecs[0], "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
